hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and flush controller for the five-stage MIPS core. It decides, every cycle, which pipeline registers hold (stall) and which get bubbled (flush), and selects the next-PC source. It covers load-use hazards, taken branches, jumps, interrupts and undefined instructions, and data-memory wait states with timeout. Its `flushIDEX` output drives the ID/EX control-zeroing mux; the stall and flush outputs drive the PC, IF/ID and EX/MEM registers.

## Interface
- `MEM_TIMEOUT`, default 15: maximum number of cycles spent in MEMWAIT before a bus error is raised. Legal range 1..255.
- `clk` in 1: pipeline clock.
- `reset` in 1: synchronous, active-high.
- `IDEX_MemRd` in 1: the instruction in EX is a load.
- `IDEX_Rt` in 5: destination register of the load in EX.
- `IFID_Rs`, `IFID_Rt` in 5 each: source registers of the instruction in ID.
- `ID_Jump` in 1: the instruction in ID is J/JAL/JR/JALR.
- `ID_Undef` in 1: the instruction in ID is an undefined opcode.
- `EX_BranchTaken` in 1: the branch in EX resolved taken.
- `irq` in 1: level interrupt request.
- `kernel_mode` in 1: interrupts are masked while this is high. It does not mask `ID_Undef`.
- `mem_req` in 1: the MEM stage is doing a load or store.
- `mem_ready` in 1: data memory has completed the access this cycle.
- `stallPC`, `stallIFID` out 1 each: hold the PC and the IF/ID register.
- `stallIDEX`, `stallEXMEM` out 1 each: hold the ID/EX and EX/MEM registers.
- `flushIFID`, `flushIDEX`, `flushEXMEM` out 1 each: load a bubble into the named register.
- `pc_sel` out 2: next-PC source. 00 = PC+4, 01 = branch target, 10 = jump target, 11 = exception vector.
- `exc_cause` out 2: valid when `pc_sel` is 11. 01 = interrupt, 10 = undefined instruction, 11 = bus error.
- `stall_cnt` out 16: count of stall cycles, saturating.

## Operation
- FSM states are RUN, MEMWAIT and EXC. Encoding is free.
- Outputs are combinational from the current state and inputs. State, the wait counter and `stall_cnt` are registered.
- Priority in RUN, highest first:
  1. Bus error.
  2. Exception: (`irq` and not `kernel_mode`) or `ID_Undef`. `irq` wins over `ID_Undef` for `exc_cause`.
  3. Memory wait: `mem_req` and not `mem_ready`.
  4. Branch taken.
  5. Load-use.
  6. Jump.
- RUN, exception: `flushIFID`=`flushIDEX`=1, `pc_sel`=11, `exc_cause` set. Next state is EXC.
- RUN, memory wait: all four stalls = 1, `flushEXMEM`=1 (bubble into MEM/WB), wait counter cleared to 1. Next state is MEMWAIT.
- RUN, branch taken: `flushIFID`=`flushIDEX`=1, `pc_sel`=01.
- RUN, load-use: `IDEX_MemRd` and `IDEX_Rt`≠0 and `IDEX_Rt` equals `IFID_Rs` or `IFID_Rt`. Outputs `stallPC`=`stallIFID`=1, `flushIDEX`=1. A jump in ID is not taken this cycle.
- RUN, jump only: `flushIFID`=1, `pc_sel`=10.
- RUN, none of the above: all outputs 0.
- MEMWAIT: same outputs as the RUN memory-wait case.
  - If `mem_ready`, next state is RUN, and branch/load-use/jump are *not* evaluated this cycle.
  - Otherwise, if the counter equals `MEM_TIMEOUT`, raise a bus error: `flushIFID`=`flushIDEX`=`flushEXMEM`=1, stalls 0, `pc_sel`=11, `exc_cause`=11. Next state is EXC.
  - Otherwise the counter increments. The counter is 8 bits.
- EXC: lasts exactly one cycle. Outputs `flushIFID`=1 and nothing else. All exception sources are ignored. Next state is RUN.
- `stall_cnt` increments in every cycle where `stallPC`=1 and saturates at 0xFFFF.

## Timing
- Reset, sampled at a rising edge, forces state RUN, wait counter 0 and `stall_cnt` 0.
- While `reset` is high, outputs are: `flushIFID`=`flushIDEX`=`flushEXMEM`=1, all stalls 0, `pc_sel`=00, `exc_cause`=00.
- Reset asserted in MEMWAIT or EXC aborts it. The first cycle after reset is RUN.
- Load-use costs exactly one bubble. In the following cycle the load is in MEM, so there is no match and no second stall.
- Branch penalty is 2 cycles, jump penalty 1 cycle, exception entry 2 cycles (entry cycle plus EXC).
- A memory access that completes in the same cycle as `mem_req` rises costs 0 cycles and never enters MEMWAIT.
- Bus error fires on the cycle where `MEM_TIMEOUT` MEMWAIT cycles have elapsed without `mem_ready`.

## Test plan
- Load-use: `lw $8` in EX, `add` using `$8` in ID. Expect one cycle with `stallPC`=`stallIFID`=`flushIDEX`=1, then all 0, and `stall_cnt`=1.
- Load to `$0` with a matching `IFID_Rs`=0: expect no stall.
- Branch taken in the same cycle as a load-use match: expect `flushIFID`=`flushIDEX`=1, `pc_sel`=01, stalls 0.
- `irq`=1 with `kernel_mode`=0: expect `pc_sel`=11, `exc_cause`=01. Next cycle EXC (`flushIFID` only, `irq` ignored), then RUN.
- `irq`=1 with `kernel_mode`=1: expect no exception.
- `mem_req`=1 with `mem_ready` low for 3 cycles then high: expect 4 cycles of all stalls, return to RUN, `stall_cnt`=4.
- `MEM_TIMEOUT`=4 and `mem_ready` never rising: expect bus error (`exc_cause`=11, three flushes) on the 4th MEMWAIT cycle, then EXC.
- Assert reset mid-MEMWAIT: expect RUN and counters cleared on the next cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush and next-PC control for the five-stage core.
// Handles load-use, branches, jumps, exceptions and data-memory waits.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IDEX_MemRd,
  input  logic [4:0]  IDEX_Rt,
  input  logic [4:0]  IFID_Rs,
  input  logic [4:0]  IFID_Rt,
  input  logic        ID_Jump,
  input  logic        ID_Undef,
  input  logic        EX_BranchTaken,
  input  logic        irq,
  input  logic        kernel_mode,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        stallPC,
  output logic        stallIFID,
  output logic        stallIDEX,
  output logic        stallEXMEM,
  output logic        flushIFID,
  output logic        flushIDEX,
  output logic        flushEXMEM,
  output logic [1:0]  pc_sel,
  output logic [1:0]  exc_cause,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN,
    MEMWAIT,
    EXC
  } state_t;

  localparam logic [7:0] TIMEOUT = MEM_TIMEOUT[7:0];

  state_t     state, stateNxt;
  logic [7:0] waitCnt, waitCntNxt;
  logic       loadUse, excReq, memWait;

  assign loadUse = IDEX_MemRd && (IDEX_Rt != 5'd0) &&
                   ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
  assign excReq  = (irq && !kernel_mode) || ID_Undef;
  assign memWait = mem_req && !mem_ready;

  always_comb begin
    stallPC    = 1'b0;
    stallIFID  = 1'b0;
    stallIDEX  = 1'b0;
    stallEXMEM = 1'b0;
    flushIFID  = 1'b0;
    flushIDEX  = 1'b0;
    flushEXMEM = 1'b0;
    pc_sel     = 2'b00;
    exc_cause  = 2'b00;
    stateNxt   = state;
    waitCntNxt = waitCnt;
    if (reset) begin
      flushIFID  = 1'b1;
      flushIDEX  = 1'b1;
      flushEXMEM = 1'b1;
      stateNxt   = RUN;
      waitCntNxt = 8'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (excReq) begin
            flushIFID = 1'b1;
            flushIDEX = 1'b1;
            pc_sel    = 2'b11;
            exc_cause = (irq && !kernel_mode) ? 2'b01 : 2'b10;
            stateNxt  = EXC;
          end else if (memWait) begin
            stallPC    = 1'b1;
            stallIFID  = 1'b1;
            stallIDEX  = 1'b1;
            stallEXMEM = 1'b1;
            flushEXMEM = 1'b1;
            waitCntNxt = 8'd1;
            stateNxt   = MEMWAIT;
          end else if (EX_BranchTaken) begin
            flushIFID = 1'b1;
            flushIDEX = 1'b1;
            pc_sel    = 2'b01;
          end else if (loadUse) begin
            stallPC   = 1'b1;
            stallIFID = 1'b1;
            flushIDEX = 1'b1;
          end else if (ID_Jump) begin
            flushIFID = 1'b1;
            pc_sel    = 2'b10;
          end
        end
        MEMWAIT: begin
          if (!mem_ready && waitCnt == TIMEOUT) begin
            flushIFID  = 1'b1;
            flushIDEX  = 1'b1;
            flushEXMEM = 1'b1;
            pc_sel     = 2'b11;
            exc_cause  = 2'b11;
            stateNxt   = EXC;
          end else begin
            stallPC    = 1'b1;
            stallIFID  = 1'b1;
            stallIDEX  = 1'b1;
            stallEXMEM = 1'b1;
            flushEXMEM = 1'b1;
            if (mem_ready) stateNxt = RUN;
            else waitCntNxt = waitCnt + 8'd1;
          end
        end
        EXC: begin
          flushIFID = 1'b1;
          stateNxt  = RUN;
        end
        default: stateNxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state   <= stateNxt;
    waitCnt <= waitCntNxt;
    if (reset)
      stall_cnt <= 16'd0;
    else if (stallPC && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table, corner sequences and randomized
// comparison against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        IDEX_MemRd;
  logic [4:0]  IDEX_Rt, IFID_Rs, IFID_Rt;
  logic        ID_Jump, ID_Undef, EX_BranchTaken;
  logic        irq, kernel_mode, mem_req, mem_ready;
  logic        stallPC, stallIFID, stallIDEX, stallEXMEM;
  logic        flushIFID, flushIDEX, flushEXMEM;
  logic [1:0]  pc_sel, exc_cause;
  logic [15:0] stall_cnt;
  logic [10:0] outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .IDEX_MemRd(IDEX_MemRd), .IDEX_Rt(IDEX_Rt),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .ID_Jump(ID_Jump), .ID_Undef(ID_Undef),
    .EX_BranchTaken(EX_BranchTaken),
    .irq(irq), .kernel_mode(kernel_mode),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .stallPC(stallPC), .stallIFID(stallIFID),
    .stallIDEX(stallIDEX), .stallEXMEM(stallEXMEM),
    .flushIFID(flushIFID), .flushIDEX(flushIDEX),
    .flushEXMEM(flushEXMEM),
    .pc_sel(pc_sel), .exc_cause(exc_cause),
    .stall_cnt(stall_cnt)
  );

  assign outs = {stallPC, stallIFID, stallIDEX, stallEXMEM,
                 flushIFID, flushIDEX, flushEXMEM,
                 pc_sel, exc_cause};

  // {stalls PC,IFID,IDEX,EXMEM}_{flushes IFID,IDEX,EXMEM}_pcSel_cause
  localparam logic [10:0] OZ   = 11'b0000_000_00_00;
  localparam logic [10:0] OLU  = 11'b1100_010_00_00;
  localparam logic [10:0] OBR  = 11'b0000_110_01_00;
  localparam logic [10:0] OJP  = 11'b0000_100_10_00;
  localparam logic [10:0] OIRQ = 11'b0000_110_11_01;
  localparam logic [10:0] OUND = 11'b0000_110_11_10;
  localparam logic [10:0] OMW  = 11'b1111_001_00_00;
  localparam logic [10:0] OBE  = 11'b0000_111_11_11;
  localparam logic [10:0] OEXC = 11'b0000_100_00_00;
  localparam logic [10:0] ORST = 11'b0000_111_00_00;

  typedef struct {
    logic       memRd;
    logic [4:0] exRt, rs, rt;
    logic       jump, undef, br, irq, km, req, rdy;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic memRd, int exRt, int rs, int rt,
                               logic jump, logic undef, logic br,
                               logic iq, logic km, logic req, logic rdy,
                               logic [10:0] exp);
    vec_t v;
    v.memRd = memRd;
    v.exRt = exRt[4:0];
    v.rs = rs[4:0];
    v.rt = rt[4:0];
    v.jump = jump;
    v.undef = undef;
    v.br = br;
    v.irq = iq;
    v.km = km;
    v.req = req;
    v.rdy = rdy;
    v.exp = exp;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic setIn(logic memRd, int exRt, int rs, int rt,
                       logic jump, logic undef, logic br,
                       logic iq, logic km, logic req, logic rdy);
    IDEX_MemRd = memRd;
    IDEX_Rt = exRt[4:0];
    IFID_Rs = rs[4:0];
    IFID_Rt = rt[4:0];
    ID_Jump = jump;
    ID_Undef = undef;
    EX_BranchTaken = br;
    irq = iq;
    kernel_mode = km;
    mem_req = req;
    mem_ready = rdy;
  endtask

  task automatic clearIn();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    clearIn();
    tick();
    reset = 1'b0;
  endtask

  // reference model state
  int mMode;
  int mIdx;
  int mStalls;

  function automatic logic [10:0] modelOut();
    logic lu;
    lu = IDEX_MemRd && IDEX_Rt != 0 &&
         (IDEX_Rt == IFID_Rs || IDEX_Rt == IFID_Rt);
    if (reset) return ORST;
    if (mMode == 2) return OEXC;
    if (mMode == 1) return (!mem_ready && mIdx == TO) ? OBE : OMW;
    if (irq && !kernel_mode) return OIRQ;
    if (ID_Undef) return OUND;
    if (mem_req && !mem_ready) return OMW;
    if (EX_BranchTaken) return OBR;
    if (lu) return OLU;
    if (ID_Jump) return OJP;
    return OZ;
  endfunction

  task automatic modelStep(logic [10:0] o);
    if (o[10] && mStalls < 65535) mStalls++;
    if (reset) begin
      mMode = 0;
      mStalls = 0;
    end else if (mMode == 2) begin
      mMode = 0;
    end else if (mMode == 1) begin
      if (mem_ready) mMode = 0;
      else if (mIdx == TO) mMode = 2;
      else mIdx++;
    end else if (o[1:0] != 2'b00) begin
      mMode = 2;
    end else if (o == OMW) begin
      mMode = 1;
      mIdx = 1;
    end
  endtask

  initial begin
    logic [10:0] e;
    reset = 1'b1;
    clearIn();

    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OZ));
    vecs.push_back(mkv(1, 8, 8, 3, 0, 0, 0, 0, 0, 0, 0, OLU));
    vecs.push_back(mkv(1, 8, 3, 8, 0, 0, 0, 0, 0, 0, 0, OLU));
    vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OZ));
    vecs.push_back(mkv(0, 8, 8, 8, 0, 0, 0, 0, 0, 0, 0, OZ));
    vecs.push_back(mkv(1, 8, 9, 10, 0, 0, 0, 0, 0, 0, 0, OZ));
    vecs.push_back(mkv(1, 8, 8, 3, 0, 0, 1, 0, 0, 0, 0, OBR));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, OJP));
    vecs.push_back(mkv(1, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0, OLU));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, OIRQ));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, OZ));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, OUND));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, OIRQ));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, OUND));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, OZ));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, OBR));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, OMW));
    vecs.push_back(mkv(1, 7, 7, 0, 1, 0, 1, 0, 0, 1, 0, OMW));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 0, OIRQ));

    #2;
    chk("resetOuts", 32'(outs), 32'(ORST));
    tick();
    chk("resetStallCnt", 32'(stall_cnt), 0);

    foreach (vecs[i]) begin
      doReset();
      setIn(vecs[i].memRd, vecs[i].exRt, vecs[i].rs, vecs[i].rt,
            vecs[i].jump, vecs[i].undef, vecs[i].br, vecs[i].irq,
            vecs[i].km, vecs[i].req, vecs[i].rdy);
      #1;
      chk($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
    end

    // load-use: one bubble, then clear
    doReset();
    setIn(1, 8, 8, 2, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("luBubble", 32'(outs), 32'(OLU));
    tick();
    clearIn();
    #1 chk("luAfter", 32'(outs), 32'(OZ));
    chk("luStallCnt", 32'(stall_cnt), 1);

    // interrupt entry, EXC ignores irq, back to RUN
    doReset();
    setIn(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    #1 chk("irqEntry", 32'(outs), 32'(OIRQ));
    tick();
    #1 chk("irqExc", 32'(outs), 32'(OEXC));
    tick();
    clearIn();
    setIn(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    #1 chk("irqRun", 32'(outs), 32'(OJP));

    // memory wait: 3 cycles not ready then ready
    doReset();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) mem_ready = 1'b1;
      #1 chk($sformatf("mwCyc%0d", c), 32'(outs), 32'(OMW));
      tick();
    end
    clearIn();
    #1 chk("mwDone", 32'(outs), 32'(OZ));
    chk("mwStallCnt", 32'(stall_cnt), 4);

    // timeout: bus error on the 4th MEMWAIT cycle
    doReset();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int c = 0; c < TO; c++) begin
      #1 chk($sformatf("toCyc%0d", c), 32'(outs), 32'(OMW));
      tick();
    end
    #1 chk("toBusErr", 32'(outs), 32'(OBE));
    tick();
    #1 chk("toExc", 32'(outs), 32'(OEXC));
    tick();
    clearIn();
    #1 chk("toRun", 32'(outs), 32'(OZ));
    chk("toStallCnt", 32'(stall_cnt), TO);

    // ready in MEMWAIT masks branch/load-use
    doReset();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    setIn(1, 6, 6, 0, 1, 0, 1, 0, 0, 1, 1);
    #1 chk("mwRdyMask", 32'(outs), 32'(OMW));
    tick();
    clearIn();
    #1 chk("mwRdyRun", 32'(outs), 32'(OZ));

    // reset mid-MEMWAIT
    doReset();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    tick();
    reset = 1'b1;
    #1 chk("midRstOuts", 32'(outs), 32'(ORST));
    tick();
    reset = 1'b0;
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1 chk("midRstRun", 32'(outs), 32'(OZ));
    chk("midRstCnt", 32'(stall_cnt), 0);

    // randomized against the reference model
    doReset();
    mMode = 0;
    mIdx = 0;
    mStalls = 0;
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom % 64) == 0;
      IDEX_MemRd = 1'($urandom % 2);
      IDEX_Rt = 5'($urandom % 4);
      IFID_Rs = 5'($urandom % 4);
      IFID_Rt = 5'($urandom % 4);
      ID_Jump = ($urandom % 4) == 0;
      ID_Undef = ($urandom % 16) == 0;
      EX_BranchTaken = ($urandom % 4) == 0;
      irq = ($urandom % 8) == 0;
      kernel_mode = 1'($urandom % 2);
      mem_req = ($urandom % 3) == 0;
      mem_ready = ($urandom % 3) != 0;
      #1;
      e = modelOut();
      chk($sformatf("rnd%0d", n), 32'(outs), 32'(e));
      chk($sformatf("rndCnt%0d", n), 32'(stall_cnt), 32'(mStalls));
      modelStep(e);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
